// File: rtl/button_event_arbiter_pkg.sv
// Shared types, constants and round-robin helper for the button event arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_evt_pkg;

    typedef enum logic [1:0] {
        DET_IDLE  = 2'd0,
        DET_PULSE = 2'd1,
        DET_WAIT  = 2'd2
    } det_state_t;

    localparam int           DROP_W   = 8;
    localparam logic [7:0]   DROP_MAX = 8'd255;
    localparam int           MAX_BTN  = 16;

    // First set bit of pend searching upward from last+1, wrapping modulo n.
    // Returns 0 when nothing is set; callers only use the result when pend != 0.
    function automatic logic [3:0] rr_pick(input logic [15:0] pend,
                                           input logic [3:0]  last,
                                           input int          n);
        logic [3:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_BTN; k++) begin
            idx = (int'(last) + k) % n;
            if ((k <= n) && !found && pend[idx]) begin
                win   = 4'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake bundle between the arbiter and its single consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds Evt_Ready low to stall; producer keeps Evt_Id stable.
interface button_event_arbiter_if #(
    parameter int ID_W = 2
) ();
    logic            Evt_Valid;
    logic            Evt_Ready;
    logic [ID_W-1:0] Evt_Id;

    modport master (output Evt_Valid, output Evt_Id, input Evt_Ready);
    modport slave  (input Evt_Valid, input Evt_Id, output Evt_Ready);
endinterface

// File: rtl/button_event_arbiter_detect.sv
// Single-button press detector: one pulse per press regardless of hold length.
// Latency: pulse is high for the cycle after the first low sample.
// Backpressure: none; the detector free-runs.
module btn_press_detect
    import btn_evt_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic btn,
    output logic pulse
);

    det_state_t state, state_nxt;

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) state <= DET_IDLE;
        else      state <= state_nxt;
    end

    // Next state and pulse; PULSE always moves to WAIT so a short tap still yields one pulse.
    always_comb begin
        state_nxt = DET_IDLE;
        pulse     = 1'b0;
        case (state)
            DET_IDLE:  state_nxt = btn ? DET_IDLE : DET_PULSE;
            DET_PULSE: begin
                pulse     = 1'b1;
                state_nxt = DET_WAIT;
            end
            DET_WAIT:  state_nxt = btn ? DET_IDLE : DET_WAIT;
            default:   state_nxt = DET_IDLE;
        endcase
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns N active-low button presses into serialised round-robin events with a minimum gap.
// Latency: first low sample at E1 -> Evt_Valid after E3 when the arbiter is idle.
// Backpressure: Evt_Valid/Evt_Id held until Evt_Ready; presses on an already-pending button are dropped and counted.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   En,
    input  logic [N_BTN-1:0]       Btn_In,
    button_event_arbiter_if.master evt,
    output logic [N_BTN-1:0]       Pending,
    output logic [DROP_W-1:0]      Drop_Count
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    logic [N_BTN-1:0]  pulse;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   winner;
    logic              grant;
    logic              accept;
    logic [GAP_W-1:0]  gap;
    logic [N_BTN-1:0]  pend_nxt;
    logic [4:0]        drop_num;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_nxt;

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_det
            btn_press_detect u_det (
                .Clk   (Clk),
                .Rst   (Rst),
                .btn   (Btn_In[g]),
                .pulse (pulse[g])
            );
        end
    endgenerate

    // Grant decision and round-robin winner selection.
    always_comb begin
        accept = evt.Evt_Valid & evt.Evt_Ready;
        grant  = En & ~evt.Evt_Valid & (gap == '0) & (|Pending);
        winner = ID_W'(rr_pick(16'(Pending), 4'(last), N_BTN));
    end

    // Pending update and drop tally; a press on the button being granted this cycle is kept, not dropped.
    always_comb begin
        logic granted_i;
        pend_nxt = Pending;
        drop_num = '0;
        for (int i = 0; i < N_BTN; i++) begin
            granted_i   = grant && (winner == ID_W'(i));
            pend_nxt[i] = (Pending[i] & ~granted_i) | pulse[i];
            if (pulse[i] && Pending[i] && !granted_i)
                drop_num = drop_num + 5'd1;
        end
        drop_sum = {1'b0, Drop_Count} + (DROP_W + 1)'(drop_num);
        drop_nxt = drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
    end

    // Pending flags and saturating drop counter.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Pending    <= '0;
            Drop_Count <= '0;
        end else begin
            Pending    <= pend_nxt;
            Drop_Count <= drop_nxt;
        end
    end

    // Output event register and round-robin pointer; grant and accept never coincide.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            evt.Evt_Valid <= 1'b0;
            evt.Evt_Id    <= '0;
            last          <= ID_W'(N_BTN - 1);
        end else if (grant) begin
            evt.Evt_Valid <= 1'b1;
            evt.Evt_Id    <= winner;
            last          <= winner;
        end else if (accept) begin
            evt.Evt_Valid <= 1'b0;
        end
    end

    // Inter-event gap counter, loaded on accept and running regardless of En.
    always_ff @(posedge Clk) begin
        if (!Rst)             gap <= '0;
        else if (accept)      gap <= GAP_W'(GAP_CYCLES);
        else if (gap != '0)   gap <= gap - 1'b1;
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N_BTN=4, GAP_CYCLES=3).
// Inputs are driven and outputs sampled on the falling edge.
// Each task owns its stimulus and inline comparisons.
module tb_button_event_arbiter;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [3:0] Btn_In;
    logic [3:0] Pending;
    logic [7:0] Drop_Count;

    int checks   = 0;
    int failures = 0;

    button_event_arbiter_if #(.ID_W(2)) evt_if ();

    button_event_arbiter #(.N_BTN(4), .GAP_CYCLES(3)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .En         (En),
        .Btn_In     (Btn_In),
        .evt        (evt_if),
        .Pending    (Pending),
        .Drop_Count (Drop_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        En = 1'b1;
        Btn_In = 4'b1111;
        evt_if.Evt_Ready = 1'b0;
        cyc(2);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        checks++;
        if (evt_if.Evt_Valid !== 1'b0 || evt_if.Evt_Id !== 2'd0 || Pending !== 4'd0 || Drop_Count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b id=%0d pending=%b drop=%0d, required 0/0/0000/0",
                     evt_if.Evt_Valid, evt_if.Evt_Id, Pending, Drop_Count);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (evt_if.Evt_Valid !== 1'b0 || Pending !== 4'd0 || Drop_Count !== 8'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_quiet: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_single_press();
        int n;
        do_reset();
        evt_if.Evt_Ready = 1'b1;
        Btn_In = 4'b1011;
        cyc(1);
        checks++;
        if (evt_if.Evt_Valid !== 1'b0) begin
            failures++;
            $display("FAIL single_e1_valid: got %b required 0", evt_if.Evt_Valid);
        end
        cyc(1);
        checks++;
        if (Pending !== 4'b0100 || evt_if.Evt_Valid !== 1'b0) begin
            failures++;
            $display("FAIL single_e2_pending: pending=%b valid=%b required 0100/0", Pending, evt_if.Evt_Valid);
        end
        cyc(1);
        checks++;
        if (evt_if.Evt_Valid !== 1'b1 || evt_if.Evt_Id !== 2'd2 || Pending !== 4'd0) begin
            failures++;
            $display("FAIL single_e3_event: valid=%b id=%0d pending=%b required 1/2/0000",
                     evt_if.Evt_Valid, evt_if.Evt_Id, Pending);
        end
        cyc(1);
        checks++;
        if (evt_if.Evt_Valid !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle: valid=%b required 0", evt_if.Evt_Valid);
        end
        n = 0;
        for (int c = 0; c < 46; c++) begin
            cyc(1);
            if (evt_if.Evt_Valid === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL single_held_no_repeat: %0d valid cycles while held, required 0", n);
        end
        Btn_In = 4'b1111;
        cyc(6);
        Btn_In = 4'b1011;
        cyc(3);
        checks++;
        if (evt_if.Evt_Valid !== 1'b1 || evt_if.Evt_Id !== 2'd2) begin
            failures++;
            $display("FAIL single_second_press: valid=%b id=%0d required 1/2", evt_if.Evt_Valid, evt_if.Evt_Id);
        end
        cyc(1);
        Btn_In = 4'b1111;
        cyc(4);
    endtask

    task automatic test_round_robin();
        int         rise_c[$];
        logic [1:0] rise_id[$];
        int         exp_c[3];
        logic [1:0] exp_id[3];
        logic       prev;
        exp_c  = '{3, 8, 13};
        exp_id = '{2'd0, 2'd1, 2'd3};
        do_reset();
        evt_if.Evt_Ready = 1'b1;
        Btn_In = 4'b0100;
        prev = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            cyc(1);
            if (evt_if.Evt_Valid === 1'b1 && !prev) begin
                rise_c.push_back(c);
                rise_id.push_back(evt_if.Evt_Id);
            end
            prev = evt_if.Evt_Valid;
        end
        checks++;
        if (rise_c.size() !== 3) begin
            failures++;
            $display("FAIL rr_count: %0d events, required 3", rise_c.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rise_id[k] !== exp_id[k] || rise_c[k] !== exp_c[k]) begin
                    failures++;
                    $display("FAIL rr_event%0d: id=%0d at cycle %0d, required id=%0d at cycle %0d",
                             k, rise_id[k], rise_c[k], exp_id[k], exp_c[k]);
                end
            end
        end
        Btn_In = 4'b1111;
        cyc(3);
    endtask

    task automatic test_backpressure_drop();
        int         hold_bad;
        int         c;
        logic [1:0] ids[$];
        do_reset();
        hold_bad = 0;
        c = 0;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                checks++;
                if (Pending !== 4'b0010 || Drop_Count !== 8'd0) begin
                    failures++;
                    $display("FAIL bp_second_press: pending=%b drop=%0d required 0010/0", Pending, Drop_Count);
                end
            end
            Btn_In = 4'b1101;
            for (int k = 0; k < 8; k++) begin
                if (k == 4) Btn_In = 4'b1111;
                cyc(1);
                c++;
                if (c >= 3 && (evt_if.Evt_Valid !== 1'b1 || evt_if.Evt_Id !== 2'd1)) hold_bad++;
            end
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL bp_hold_stable: %0d cycles not holding id 1, required 0", hold_bad);
        end
        checks++;
        if (Pending !== 4'b0010 || Drop_Count !== 8'd1) begin
            failures++;
            $display("FAIL bp_drop: pending=%b drop=%0d required 0010/1", Pending, Drop_Count);
        end
        evt_if.Evt_Ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (evt_if.Evt_Valid === 1'b1 && evt_if.Evt_Ready === 1'b1) ids.push_back(evt_if.Evt_Id);
            cyc(1);
        end
        checks++;
        if (ids.size() !== 2) begin
            failures++;
            $display("FAIL bp_drain_count: %0d events, required 2", ids.size());
        end else begin
            checks++;
            if (ids[0] !== 2'd1 || ids[1] !== 2'd1) begin
                failures++;
                $display("FAIL bp_drain_ids: %0d,%0d required 1,1", ids[0], ids[1]);
            end
        end
        checks++;
        if (Pending !== 4'd0 || Drop_Count !== 8'd1) begin
            failures++;
            $display("FAIL bp_final: pending=%b drop=%0d required 0000/1", Pending, Drop_Count);
        end
    endtask

    task automatic test_enable_gating();
        int         vbad;
        logic [1:0] ids[$];
        do_reset();
        En = 1'b0;
        evt_if.Evt_Ready = 1'b1;
        Btn_In = 4'b1010;
        vbad = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            if (evt_if.Evt_Valid !== 1'b0) vbad++;
        end
        checks++;
        if (Pending !== 4'b0101 || vbad !== 0) begin
            failures++;
            $display("FAIL en_gated: pending=%b valid_cycles=%0d required 0101/0", Pending, vbad);
        end
        Btn_In = 4'b1111;
        En = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (evt_if.Evt_Valid === 1'b1 && evt_if.Evt_Ready === 1'b1) ids.push_back(evt_if.Evt_Id);
        end
        checks++;
        if (ids.size() !== 2) begin
            failures++;
            $display("FAIL en_count: %0d events, required 2", ids.size());
        end else begin
            checks++;
            if (ids[0] !== 2'd0 || ids[1] !== 2'd2) begin
                failures++;
                $display("FAIL en_order: %0d,%0d required 0,2", ids[0], ids[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int vbad;
        do_reset();
        for (int p = 0; p < 7; p++) begin
            Btn_In = 4'b0111;
            cyc(2);
            Btn_In = 4'b1111;
            cyc(2);
        end
        cyc(1);
        checks++;
        if (evt_if.Evt_Valid !== 1'b1 || evt_if.Evt_Id !== 2'd3 || Pending !== 4'b1000 || Drop_Count !== 8'd5) begin
            failures++;
            $display("FAIL rst_setup: valid=%b id=%0d pending=%b drop=%0d required 1/3/1000/5",
                     evt_if.Evt_Valid, evt_if.Evt_Id, Pending, Drop_Count);
        end
        Rst = 1'b0;
        cyc(1);
        Rst = 1'b1;
        checks++;
        if (evt_if.Evt_Valid !== 1'b0 || evt_if.Evt_Id !== 2'd0 || Pending !== 4'd0 || Drop_Count !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_clear: valid=%b id=%0d pending=%b drop=%0d required 0/0/0000/0",
                     evt_if.Evt_Valid, evt_if.Evt_Id, Pending, Drop_Count);
        end
        evt_if.Evt_Ready = 1'b1;
        vbad = 0;
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            if (evt_if.Evt_Valid !== 1'b0 || Pending !== 4'd0) vbad++;
        end
        checks++;
        if (vbad !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: %0d active cycles after reset, required 0", vbad);
        end
    endtask

    initial begin
        Rst = 1'b0;
        En = 1'b1;
        Btn_In = 4'b1111;
        evt_if.Evt_Ready = 1'b0;
        cyc(1);
        test_reset();
        test_single_press();
        test_round_robin();
        test_backpressure_drop();
        test_enable_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Collects N active-low push-buttons and turns each press into exactly one event. Events are serialised onto a single valid/ready event port using round-robin arbitration, with a programmable minimum gap between delivered events. Sits between the synchronised button pins and the single consumer FSM (menu/game control), replacing per-button pulse wiring. Presses that arrive while the same button already has an undelivered event are dropped and counted.

Parameters:
N_BTN, 4, number of buttons (2..16)
GAP_CYCLES, 3, idle cycles enforced after each accepted event (0 allowed)
ID_W, clog2(N_BTN), derived localparam: event id width

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-low
En  in  1  1 = grants allowed; 0 = press detection and pending capture continue, no new grants
Btn_In  in  N_BTN  raw button levels, active-low, already synchronised to Clk
Evt_Valid  out  1  event available
Evt_Ready  in  1  consumer accepts event when Evt_Valid & Evt_Ready at a rising edge
Evt_Id  out  ID_W  index of the button that produced the event
Pending  out  N_BTN  per-button undelivered-press flags
Drop_Count  out  8  saturating count of dropped presses

Behaviour:
- Reset (Rst=0 sampled at posedge): all detectors IDLE; Pending=0; Evt_Valid=0; Evt_Id=0; gap counter=0; RR last-grant pointer=N_BTN-1, so button 0 has top priority first; Drop_Count=0. Reset mid-handshake discards the held event and all pending presses.
- Per-button press detector, 3 states:
  - IDLE: pulse=0; Btn_In[i]=0 -> PULSE, else stay.
  - PULSE: pulse=1; -> WAIT unconditionally, even if the button is already released.
  - WAIT: pulse=0; Btn_In[i]=1 -> IDLE, else stay.
  - Result: one pulse per press, regardless of hold length. Illegal encoding -> IDLE with pulse=0.
- Pending capture, at each edge:
  - pulse[i]=1 and Pending[i]=0 -> Pending[i] set.
  - pulse[i]=1, Pending[i]=1, and i not granted this cycle -> press dropped; Drop_Count+1, saturating at 255.
  - pulse[i]=1 and i granted in the same cycle -> Pending[i] stays 1 (new press captured, nothing dropped).
  - Grant clears Pending[i] unless re-set by the rule above.
- Grant condition: En=1 & Evt_Valid=0 & gap==0 & |Pending.
  - Winner = first set Pending bit searching from last+1 upward, wrapping modulo N_BTN.
  - At the edge: Evt_Id<=winner, Evt_Valid<=1, last<=winner, Pending[winner] cleared.
- Output hold: while Evt_Valid=1 and Evt_Ready=0, Evt_Id is stable; no new grant.
- Accept edge (Evt_Valid & Evt_Ready): Evt_Valid<=0, gap<=GAP_CYCLES. Gap decrements by 1 each cycle while nonzero, saturating at 0; it counts down even when En=0.
- Latency: Btn_In[i] first sampled low at edge E1 -> pulse during the cycle after E1 -> Pending set at E2 -> Evt_Valid=1 after E3, when the arbiter is idle.
- Throughput: accept at edge A -> earliest next Evt_Valid after edge A+GAP_CYCLES+1. With GAP_CYCLES=0 the maximum rate is 1 event per 2 cycles.
- Evt_Ready is ignored while Evt_Valid=0.

Decomposition:
- Package btn_evt_pkg:
  - Detector state enum: DET_IDLE, DET_PULSE, DET_WAIT.
  - DROP_W=8 and DROP_MAX=255.
  - Round-robin pick function: pending vector and last index in, winner index out.
- Sub-module btn_press_detect: the single-button 3-state detector, instantiated N_BTN times via generate.
- Arbiter, gap counter, output register and drop counter stay in the top.

Test Plan:
1. Reset then idle: Btn_In=4'b1111 for 20 cycles -> Evt_Valid=0, Pending=0, Drop_Count=0 throughout.
2. Single press latency: Btn_In[2] low for 50 cycles with Evt_Ready=1 -> exactly one event with Evt_Id=2, Evt_Valid high after 3rd edge following first low sample, for one cycle. No further events while held; release then press again -> second event.
3. Round-robin: buttons 0, 1, 3 pressed in the same cycle, Evt_Ready=1, GAP_CYCLES=3 -> ids 0, 1, 3 in order, successive Evt_Valid rises 5 cycles apart.
4. Backpressure and drop: Evt_Ready=0; press button 1 three times (press/release 4 cycles each) -> first event held with Evt_Id=1 stable; Pending[1]=1 after the 2nd press, 3rd press dropped, Drop_Count=1. Raise Evt_Ready -> ids 1 then 1, nothing else.
5. Enable gating: En=0, press buttons 0 and 2 -> Pending=4'b0101, no Evt_Valid. En=1 -> events 0 then 2.
6. Reset mid-operation: Evt_Valid=1, Pending=4'b1000, Drop_Count=5, assert Rst=0 for 1 cycle -> next cycle all outputs 0; with the button released before Rst returns high, no event follows.
